// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Moore control FSM for a multicycle RV32I-subset datapath (loads, stores,
//   R-type, I-type ALU, beq/bne, jal). It sequences fetch, decode, address
//   generation, memory wait states and write-back. It also decodes the
//   immediate format and the ALU operation.
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_rst_n        synchronous active-low reset
//   i_op           instr[6:0]
//   i_funct3       instr[14:12]
//   i_funct7b5     instr[30]
//   i_zero         ALU zero flag (branch decision)
//   i_mem_ready    memory access completes in the cycle this is high
//   o_pc_write     PC load enable
//   o_adr_src      memory address select (0 = PC, 1 = ALU result)
//   o_ir_write     instruction register load enable
//   o_reg_write    register file write enable
//   o_mem_write    data memory write enable
//   o_result_src   result mux select
//   o_alu_src_a    ALU operand A select
//   o_alu_src_b    ALU operand B select
//   o_imm_src      immediate format select
//   o_alu_control  ALU operation
//   o_illegal      one-cycle pulse in DECODE for an unsupported opcode
//   o_state        current state code (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_adr_src,
  output logic       o_ir_write,
  output logic       o_reg_write,
  output logic       o_mem_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_imm_src,
  output logic [2:0] o_alu_control,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t state_q;
  state_t state_d;

  logic       pc_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       mem_write_raw;
  logic       illegal_raw;
  logic [1:0] alu_op;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order races.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every signal written in a combinational block gets a default first;
  // a missing branch would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (i_mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (i_op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      // The instruction register holds the opcode, so i_op is still valid here.
      S_MEMADR:   state_d = (i_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (i_mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (i_mem_ready) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state control outputs (Moore, except the handshake/flag qualified
  // enables in FETCH and BRANCH).
  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    o_adr_src     = 1'b0;
    o_result_src  = 2'b00;
    o_alu_src_a   = 2'b00;
    o_alu_src_b   = 2'b00;
    alu_op        = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
        ir_write_raw = i_mem_ready;
        pc_write_raw = i_mem_ready;
      end
      S_DECODE: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
        illegal_raw = !(i_op inside {OP_LOAD, OP_STORE, OP_RTYPE,
                                     OP_ITYPE, OP_BRANCH, OP_JAL});
      end
      S_MEMADR: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
      end
      S_MEMREAD: o_adr_src = 1'b1;
      S_MEMWRITE: begin
        o_adr_src     = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_MEMWB: begin
        o_result_src  = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_EXECR: begin
        o_alu_src_a = 2'b10;
        alu_op      = 2'b10;
      end
      S_EXECI: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        alu_op      = 2'b10;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BRANCH: begin
        o_alu_src_a  = 2'b10;
        alu_op       = 2'b01;
        pc_write_raw = ((i_funct3 == 3'b000) &&  i_zero) ||
                       ((i_funct3 == 3'b001) && !i_zero);
      end
      S_JAL: begin
        o_alu_src_a  = 2'b01;
        o_alu_src_b  = 2'b10;
        pc_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format depends only on the opcode, in every state.
  always_comb begin
    unique case (i_op)
      OP_STORE:  o_imm_src = 2'b01;
      OP_BRANCH: o_imm_src = 2'b10;
      OP_JAL:    o_imm_src = 2'b11;
      default:   o_imm_src = 2'b00;
    endcase
  end

  // ALU decoder. Only R-type (op[5] set) turns funct3=000 with funct7b5 into sub;
  // addi with a negative immediate must stay an add.
  always_comb begin
    o_alu_control = 3'b000;
    unique case (alu_op)
      2'b01: o_alu_control = 3'b001;
      2'b10: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_op[5] && i_funct7b5) ? 3'b001 : 3'b000;
          3'b010:  o_alu_control = 3'b101;
          3'b110:  o_alu_control = 3'b011;
          3'b111:  o_alu_control = 3'b010;
          default: o_alu_control = 3'b000;
        endcase
      end
      default: o_alu_control = 3'b000;
    endcase
  end

  // Side-effecting enables are suppressed while reset is held, whatever state
  // the register still shows during that cycle.
  assign o_pc_write  = pc_write_raw  & i_rst_n;
  assign o_ir_write  = ir_write_raw  & i_rst_n;
  assign o_reg_write = reg_write_raw & i_rst_n;
  assign o_mem_write = mem_write_raw & i_rst_n;
  assign o_illegal   = illegal_raw   & i_rst_n;
  assign o_state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Drives whole instructions into multicycle_ctrl. A reference model plans
//   each instruction as a list of states plus memory-ready handshakes, and it
//   pushes the expected control word for every cycle into a scoreboard queue.
//   A monitor process on the falling edge pops the queue and compares it with
//   the DUT outputs.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal;
  } ctrl_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [6:0] i_op;
  logic [2:0] i_funct3;
  logic       i_funct7b5;
  logic       i_zero;
  logic       i_mem_ready;
  logic       o_pc_write, o_adr_src, o_ir_write, o_reg_write, o_mem_write;
  logic [1:0] o_result_src, o_alu_src_a, o_alu_src_b, o_imm_src;
  logic [2:0] o_alu_control;
  logic       o_illegal;
  logic [3:0] o_state;

  int checks   = 0;
  int failures = 0;
  int instr_no = 0;

  ctrl_t exp_q[$];
  int    id_q[$];

  multicycle_ctrl dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_op          (i_op),
    .i_funct3      (i_funct3),
    .i_funct7b5    (i_funct7b5),
    .i_zero        (i_zero),
    .i_mem_ready   (i_mem_ready),
    .o_pc_write    (o_pc_write),
    .o_adr_src     (o_adr_src),
    .o_ir_write    (o_ir_write),
    .o_reg_write   (o_reg_write),
    .o_mem_write   (o_mem_write),
    .o_result_src  (o_result_src),
    .o_alu_src_a   (o_alu_src_a),
    .o_alu_src_b   (o_alu_src_b),
    .o_imm_src     (o_imm_src),
    .o_alu_control (o_alu_control),
    .o_illegal     (o_illegal),
    .o_state       (o_state)
  );

  always #5 i_clk = ~i_clk;

  // Expected control word for one cycle, given the state the plan says the
  // machine is in and the inputs applied during that cycle.
  function automatic ctrl_t model(int st, bit rst_n, bit rdy, bit z,
                                  logic [6:0] op, logic [2:0] f3, bit f7);
    ctrl_t e;
    e = '0;
    e.state = 4'(st);
    if      (op == OP_STORE)  e.imm_src = 2'b01;
    else if (op == OP_BRANCH) e.imm_src = 2'b10;
    else if (op == OP_JAL)    e.imm_src = 2'b11;
    case (st)
      0: begin e.alu_src_b = 2; e.result_src = 2; e.ir_write = rdy; e.pc_write = rdy; end
      1: begin
        e.alu_src_a = 1; e.alu_src_b = 1;
        e.illegal = !(op == OP_LOAD || op == OP_STORE || op == OP_RTYPE ||
                      op == OP_ITYPE || op == OP_BRANCH || op == OP_JAL);
      end
      2: begin e.alu_src_a = 2; e.alu_src_b = 1; end
      3: e.adr_src = 1;
      4: begin e.result_src = 1; e.reg_write = 1; end
      5: begin e.adr_src = 1; e.mem_write = 1; end
      6, 7: begin
        e.alu_src_a = 2;
        e.alu_src_b = (st == 7) ? 2'd1 : 2'd0;
        if      (f3 == 3'd0) e.alu_control = (op[5] && f7) ? 3'd1 : 3'd0;
        else if (f3 == 3'd2) e.alu_control = 3'd5;
        else if (f3 == 3'd6) e.alu_control = 3'd3;
        else if (f3 == 3'd7) e.alu_control = 3'd2;
      end
      8: e.reg_write = 1;
      9: begin
        e.alu_src_a = 2; e.alu_control = 3'd1;
        e.pc_write = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
      end
      10: begin e.alu_src_a = 1; e.alu_src_b = 2; e.pc_write = 1; end
      default: ;
    endcase
    if (!rst_n) begin
      e.pc_write = 0; e.ir_write = 0; e.reg_write = 0; e.mem_write = 0; e.illegal = 0;
    end
    return e;
  endfunction

  // Apply one cycle of inputs just after the rising edge and queue its expectation.
  task automatic drive_cycle(bit rst_n, bit rdy, bit z, int st,
                             logic [6:0] op, logic [2:0] f3, bit f7);
    @(posedge i_clk);
    #1;
    i_rst_n     = rst_n;
    i_mem_ready = rdy;
    i_zero      = z;
    i_op        = op;
    i_funct3    = f3;
    i_funct7b5  = f7;
    exp_q.push_back(model(st, rst_n, rdy, z, op, f3, f7));
    id_q.push_back(instr_no);
  endtask

  // Plan an instruction as a state list with handshakes, then run it.
  // rst_at >= 0 asserts reset in that cycle of the plan and abandons the rest.
  task automatic run_instr(logic [6:0] op, logic [2:0] f3, bit f7, bit z,
                           int fw, int mw, int rst_at);
    int st_plan[$];
    bit rdy_plan[$];
    repeat (fw) begin st_plan.push_back(0); rdy_plan.push_back(1'b0); end
    st_plan.push_back(0); rdy_plan.push_back(1'b1);
    st_plan.push_back(1); rdy_plan.push_back(1'($urandom));
    if (op == OP_LOAD || op == OP_STORE) begin
      int mst;
      mst = (op == OP_LOAD) ? 3 : 5;
      st_plan.push_back(2); rdy_plan.push_back(1'($urandom));
      repeat (mw) begin st_plan.push_back(mst); rdy_plan.push_back(1'b0); end
      st_plan.push_back(mst); rdy_plan.push_back(1'b1);
      if (op == OP_LOAD) begin st_plan.push_back(4); rdy_plan.push_back(1'($urandom)); end
    end else if (op == OP_RTYPE || op == OP_ITYPE) begin
      st_plan.push_back((op == OP_RTYPE) ? 6 : 7); rdy_plan.push_back(1'($urandom));
      st_plan.push_back(8); rdy_plan.push_back(1'($urandom));
    end else if (op == OP_BRANCH) begin
      st_plan.push_back(9); rdy_plan.push_back(1'($urandom));
    end else if (op == OP_JAL) begin
      st_plan.push_back(10); rdy_plan.push_back(1'($urandom));
      st_plan.push_back(8); rdy_plan.push_back(1'($urandom));
    end
    instr_no++;
    for (int i = 0; i < st_plan.size(); i++) begin
      bit rst_n;
      bit zz;
      rst_n = (i != rst_at);
      zz    = (st_plan[i] == 9) ? z : 1'($urandom);
      drive_cycle(rst_n, rdy_plan[i], zz, st_plan[i], op, f3, f7);
      if (!rst_n) break;
    end
  endtask

  task automatic check(int id, ctrl_t act, ctrl_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL ctrl instr=%0d state got=%0d want=%0d word got=%h want=%h",
               id, act.state, exp.state, act, exp);
    end
  endtask

  // Monitor: every falling edge with a pending expectation is a comparison.
  initial begin
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        ctrl_t act;
        act = {o_state, o_pc_write, o_adr_src, o_ir_write, o_reg_write, o_mem_write,
               o_result_src, o_alu_src_a, o_alu_src_b, o_imm_src, o_alu_control, o_illegal};
        check(id_q.pop_front(), act, exp_q.pop_front());
      end
    end
  end

  initial begin
    i_rst_n = 1'b0; i_mem_ready = 1'b0; i_zero = 1'b0;
    i_op = '0; i_funct3 = '0; i_funct7b5 = 1'b0;

    // Reset held with mem_ready high: FETCH state, enables forced low.
    drive_cycle(1'b0, 1'b1, 1'b0, 0, OP_LOAD, 3'd0, 1'b0);

    run_instr(OP_LOAD,   3'd2, 1'b0, 1'b0, 0, 2, -1);  // lw, two wait cycles
    run_instr(OP_STORE,  3'd2, 1'b0, 1'b0, 1, 1, -1);  // sw with fetch wait
    run_instr(OP_RTYPE,  3'd0, 1'b1, 1'b0, 0, 0, -1);  // sub
    run_instr(OP_RTYPE,  3'd0, 1'b0, 1'b0, 0, 0, -1);  // add
    run_instr(OP_RTYPE,  3'd2, 1'b0, 1'b0, 0, 0, -1);  // slt
    run_instr(OP_RTYPE,  3'd6, 1'b0, 1'b0, 0, 0, -1);  // or
    run_instr(OP_RTYPE,  3'd7, 1'b0, 1'b0, 0, 0, -1);  // and
    run_instr(OP_ITYPE,  3'd0, 1'b1, 1'b0, 0, 0, -1);  // addi, funct7b5 ignored
    run_instr(OP_BRANCH, 3'd0, 1'b0, 1'b1, 0, 0, -1);  // beq taken
    run_instr(OP_BRANCH, 3'd0, 1'b0, 1'b0, 0, 0, -1);  // beq not taken
    run_instr(OP_BRANCH, 3'd1, 1'b0, 1'b1, 0, 0, -1);  // bne not taken
    run_instr(OP_BRANCH, 3'd1, 1'b0, 1'b0, 0, 0, -1);  // bne taken
    run_instr(OP_JAL,    3'd0, 1'b0, 1'b0, 0, 0, -1);  // jal
    run_instr(OP_BAD,    3'd0, 1'b0, 1'b0, 0, 0, -1);  // illegal opcode
    run_instr(OP_STORE,  3'd2, 1'b0, 1'b0, 0, 3, 4);   // reset mid-MEMWRITE wait
    run_instr(OP_LOAD,   3'd2, 1'b0, 1'b0, 0, 0, -1);  // clean restart after reset

    for (int n = 0; n < 200; n++) begin
      logic [6:0] op;
      int pick;
      int fw;
      int mw;
      int rst_at;
      pick = $urandom_range(0, 7);
      case (pick)
        0: op = OP_LOAD;
        1: op = OP_STORE;
        2: op = OP_RTYPE;
        3: op = OP_ITYPE;
        4: op = OP_BRANCH;
        5: op = OP_JAL;
        6: op = OP_BAD;
        default: op = 7'($urandom);
      endcase
      fw     = $urandom_range(0, 2);
      mw     = $urandom_range(0, 3);
      rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), fw, mw, rst_at);
    end

    @(negedge i_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port i_op, input, 7 bits: instruction opcode, instr[6:0].
REQ-004 SHALL have ports i_funct3, input, 3 bits, and i_funct7b5, input, 1 bit: instr[14:12] and instr[30].
REQ-005 SHALL have port i_zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have port i_mem_ready, input, 1 bit: memory access completes in the cycle it is high.
REQ-007 SHALL have output ports o_pc_write, o_adr_src, o_ir_write, o_reg_write and o_mem_write, 1 bit each.
REQ-008 SHALL have output ports o_result_src, o_alu_src_a, o_alu_src_b and o_imm_src, 2 bits each.
REQ-009 SHALL have output ports o_alu_control, 3 bits; o_illegal, 1 bit; o_state, 4 bits (state code, debug).

Function
REQ-010 SHALL implement a Moore FSM with these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10.
REQ-011 SHALL make these transitions:
- FETCH->DECODE when i_mem_ready=1, else stay in FETCH.
- DECODE->MEMADR on op 0000011 or 0100011.
- DECODE->EXECR on op 0110011.
- DECODE->EXECI on op 0010011.
- DECODE->BRANCH on op 1100011.
- DECODE->JAL on op 1101111.
- DECODE->FETCH on any other op.
REQ-012 SHALL leave MEMADR to MEMREAD for a load and to MEMWRITE for a store.
REQ-013 SHALL hold in MEMREAD and MEMWRITE until i_mem_ready=1, then go MEMREAD->MEMWB and MEMWRITE->FETCH.
REQ-014 SHALL go MEMWB->FETCH, EXECR->ALUWB, EXECI->ALUWB, ALUWB->FETCH, BRANCH->FETCH and JAL->ALUWB.
REQ-015 SHALL drive, in FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, with ir_write=pc_write=i_mem_ready.
REQ-016 SHALL drive, in DECODE: alu_src_a=01, alu_src_b=01 (branch target precompute).
REQ-017 SHALL drive, in MEMADR: alu_src_a=10, alu_src_b=01.
REQ-018 SHALL drive, in MEMREAD: adr_src=1, result_src=00.
REQ-019 SHALL drive, in MEMWRITE: adr_src=1, result_src=00, mem_write=1 for every cycle in the state.
REQ-020 SHALL drive, in MEMWB: result_src=01, reg_write=1.
REQ-021 SHALL drive, in EXECR: alu_src_a=10, alu_src_b=00; and in EXECI: alu_src_a=10, alu_src_b=01.
REQ-022 SHALL drive, in ALUWB: result_src=00, reg_write=1.
REQ-023 SHALL drive, in BRANCH: alu_src_a=10, alu_src_b=00, result_src=00, and pc_write=(funct3=000 & zero) | (funct3=001 & !zero).
REQ-024 SHALL drive, in JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1.
REQ-025 SHALL drive 0 on every 1-bit and 2-bit control output not listed for the current state.
REQ-026 SHALL decode o_imm_src combinationally from i_op in every state: 0000011/0010011->00, 0100011->01, 1100011->10, 1101111->11, other->00.
REQ-027 SHALL use internal alu_op=10 in EXECR/EXECI, 01 in BRANCH, 00 otherwise.
REQ-028 SHALL map alu_op to o_alu_control as follows:
- alu_op 00 -> 000 (add).
- alu_op 01 -> 001 (sub).
- alu_op 10 -> by funct3: 000 gives 001 if (i_op[5] & i_funct7b5) else 000; 010->101; 110->011; 111->010; other->000.
REQ-029 SHALL pulse o_illegal for exactly one cycle, in the DECODE cycle that takes the DECODE->FETCH default path.
REQ-030 SHALL drive o_mem_write and o_reg_write high in no state other than those listed in REQ-019, REQ-020 and REQ-022.

Reset
REQ-031 SHALL, when i_rst_n=0 at a rising edge, enter FETCH regardless of current state, including mid-MEMWRITE or mid-wait.
REQ-032 SHALL, while i_rst_n=0, force o_pc_write, o_ir_write, o_reg_write, o_mem_write and o_illegal to 0.
REQ-033 SHALL, on the first cycle after reset release, present FETCH outputs and o_state=0.

Verification
REQ-034 SHALL cover: reset mid-MEMWRITE with i_mem_ready=0 -> next cycle o_state=0 and o_mem_write=0.
REQ-035 SHALL cover: lw (op 0000011) with i_mem_ready low 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; o_reg_write=1 only in state 4; o_imm_src=00.
REQ-036 SHALL cover: R-type sub (funct3=000, funct7b5=1) -> EXECR gives o_alu_control=001; ALUWB gives o_reg_write=1.
REQ-037 SHALL cover: beq with i_zero=1 -> o_pc_write=1 in BRANCH; with i_zero=0 -> 0; bne (funct3=001) gives the inverse; o_imm_src=10.
REQ-038 SHALL cover: jal -> states 0,1,10,8,0; o_pc_write=1 in JAL; o_imm_src=11.
REQ-039 SHALL cover: op 1111111 -> o_illegal=1 for one cycle in DECODE, then FETCH, with no reg_write or mem_write asserted.
